// File: rtl/calc_alu.sv
// calc_alu: iterative add/sub/shift-add multiply/restoring divide
// with start/busy/done handshake and registered, held results.
module calc_alu #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [W-1:0]   op_a,
  input  logic [W-1:0]   op_b,
  input  logic [1:0]     op_sel,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] result,
  output logic [W-1:0]   remainder,
  output logic           neg,
  output logic           err
);

  localparam int CW = $clog2(W + 1);
  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         r_state;
  logic [CW-1:0]  r_cnt;
  logic [1:0]     r_sel;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [2*W-1:0] r_mcand;
  logic [2*W-1:0] r_acc;
  logic [W-1:0]   r_rem;
  logic [W-1:0]   r_quo;
  logic           r_busy;
  logic           r_done;
  logic [2*W-1:0] r_result;
  logic [W-1:0]   r_remainder;
  logic           r_neg;
  logic           r_err;

  logic [2*W-1:0] w_sum;
  logic [W-1:0]   w_diff;
  logic [2*W-1:0] w_acc_nx;
  logic [W:0]     w_shift;
  logic [W:0]     w_trial;
  logic           w_ge;
  logic [W-1:0]   w_rem_nx;
  logic [W-1:0]   w_quo_nx;
  logic           w_last;

  assign w_sum    = (2*W)'(r_a) + (2*W)'(r_b);
  assign w_diff   = (r_a >= r_b) ? r_a - r_b : r_b - r_a;
  assign w_acc_nx = r_b[0] ? r_acc + r_mcand : r_acc;

  // Trial subtract; the borrow bit decides restore vs. keep.
  assign w_shift  = {r_rem, r_quo[W-1]};
  assign w_trial  = w_shift - {1'b0, r_b};
  assign w_ge     = ~w_trial[W];
  assign w_rem_nx = w_ge ? w_trial[W-1:0] : w_shift[W-1:0];
  assign w_quo_nx = {r_quo[W-2:0], w_ge};
  assign w_last   = (r_cnt == CW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_sel       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_mcand     <= '0;
      r_acc       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_result    <= '0;
      r_remainder <= '0;
      r_neg       <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state <= CALC;
            r_busy  <= 1'b1;
            r_sel   <= op_sel;
            r_a     <= op_a;
            r_b     <= op_b;
            r_mcand <= (2*W)'(op_a);
            r_acc   <= '0;
            r_rem   <= '0;
            r_quo   <= op_a;
            r_cnt   <= (op_sel[1]) ? CW'(W) : CW'(1);
          end
        end
        CALC: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_sel == OP_MUL) begin
            r_acc   <= w_acc_nx;
            r_mcand <= r_mcand << 1;
            r_b     <= r_b >> 1;
          end
          if (r_sel == OP_DIV) begin
            r_rem <= w_rem_nx;
            r_quo <= w_quo_nx;
          end
          if (w_last) begin
            r_state     <= DONE;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_remainder <= '0;
            r_neg       <= 1'b0;
            r_err       <= 1'b0;
            case (r_sel)
              OP_ADD: r_result <= w_sum;
              OP_SUB: begin
                r_result <= (2*W)'(w_diff);
                r_neg    <= (r_a < r_b);
              end
              OP_MUL: r_result <= w_acc_nx;
              OP_DIV: begin
                if (r_b == '0) begin
                  r_result <= '0;
                  r_err    <= 1'b1;
                end else begin
                  r_result    <= (2*W)'(w_quo_nx);
                  r_remainder <= w_rem_nx;
                end
              end
            endcase
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign result    = r_result;
  assign remainder = r_remainder;
  assign neg       = r_neg;
  assign err       = r_err;

endmodule

// File: doc/calc_alu.md
# calc_alu

Iterative arithmetic stage of the calculator, directly downstream of the switch-capture stage. It consumes the two latched 4-bit operands (first operand register → `op_a`, second operand register → `op_b`) plus an operation code. It computes add, subtract, shift-add multiply or restoring divide under a start/busy/done handshake. Results are held stable for the display stage until the next completion.

## Interface
Parameters:
- `W`, 4: operand width; the result is `2*W` bits wide.

Ports:
- `clk`  in  1: single clock, rising-edge.
- `rst`  in  1: asynchronous, active-high reset.
- `op_a`  in  W: first operand, unsigned.
- `op_b`  in  W: second operand, unsigned.
- `op_sel`  in  2: operation code. 0 = add, 1 = subtract, 2 = multiply, 3 = divide.
- `start`  in  1: request; sampled only in IDLE.
- `busy`  out  1: high while an operation is in progress.
- `done`  out  1: one-cycle completion pulse.
- `result`  out  2W: sum, absolute difference, product, or quotient.
- `remainder`  out  W: division remainder; 0 for all other operations.
- `neg`  out  1: subtract result was negative (`op_a < op_b`).
- `err`  out  1: divide by zero.

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE with `start=1` at an edge:
  - latch `op_a`, `op_b` and `op_sel` into internal registers;
  - load the iteration counter with N (N = 1 for add/sub, N = W for mul/div);
  - go to CALC.
- IDLE with `start=0`: stay in IDLE.
- CALC: perform one iteration per clock and decrement the counter. On the edge that completes the last iteration:
  - write `result`, `remainder`, `neg` and `err`;
  - go to DONE.
- DONE: lasts exactly one cycle, then the FSM returns to IDLE unconditionally.
- `start` is ignored in CALC and DONE. It is not queued.
- Input changes on `op_a`, `op_b` or `op_sel` after acceptance have no effect, because the operands were latched.
- Add: `result = op_a + op_b`, zero-extended (max 30). `neg=0`, `err=0`, `remainder=0`.
- Subtract: `result[W-1:0] = |op_a − op_b|`, upper bits 0. `neg = (op_a < op_b)`. `err=0`, `remainder=0`.
- Multiply: shift-add over W iterations. Each iteration examines one bit of the multiplier, LSB first, and adds the shifted multiplicand into a 2W accumulator. The final product is exact (max 225). `neg=0`, `err=0`, `remainder=0`.
- Divide: restoring division over W iterations, MSB first, with a (W+1)-bit partial remainder. `result[W-1:0]` = quotient, upper bits 0; `remainder` = remainder.
- Divide by zero (`op_b=0` at acceptance): still runs W iterations (latency unchanged). At completion it forces `result=0`, `remainder=0`, `err=1`.
- `neg` and `err` are rewritten at every completion, so they reflect only the latest operation.
- Internal accumulator and intermediate values are not visible on the outputs until completion.

## Timing
- Reset (asynchronous, immediate, including mid-operation): state IDLE, counter 0, and every output is 0 (`busy`, `done`, `result`, `remainder`, `neg`, `err`). Any operation in progress is discarded.
- After reset deassertion, the first edge with `start=1` begins an operation.
- Latency, with start accepted at edge k:
  - `busy=1` from after edge k through edge k+N;
  - the result is written at edge k+N;
  - `done=1` for the single cycle following edge k+N, and `busy=0` in that cycle.
  - Add/sub: `done` follows edge k+1. Mul/div: `done` follows edge k+4.
- `busy` and `done` are never high together.
- The earliest next acceptance is edge k+N+2 (the first IDLE edge after DONE). With `start` held high, operations repeat every N+2 cycles.
- Outputs are registered and hold their values between completions.

## Test plan
- Reset mid-multiply: assert `rst` two cycles after starting 15×15. Required: all outputs 0 immediately. The next start with 3+4 gives `result=7`, `done` one cycle later.
- Add/sub: 9+7 gives `result=16`, `done` after edge k+1. Then 3−10 gives `result=7`, `neg=1`. Then 10−3 gives `result=7`, `neg=0`.
- Multiply: 15×15 gives `result=225`, `busy` high for 4 cycles, `done` after edge k+4. 0×9 gives `result=0`. Change `op_a` during busy: result unchanged.
- Divide: 13÷4 gives `result=3`, `remainder=1`. 4÷13 gives `result=0`, `remainder=4`. 7÷0 gives `err=1`, `result=0`, `remainder=0`, latency still 4. A following 8÷2 clears `err` and gives `result=4`.
- Handshake: pulse `start` during CALC and during DONE; required: ignored. Hold `start` high with add: `done` pulses every 3 cycles.
- Random regression: 1000 random operands and opcodes checked against a reference model. Required: `busy` and `done` never high together, and every latency equals N.
